// File: rtl/mau_pkg.sv
// Shared types and defaults for the memory access unit: FSM states,
// default geometry and the width of the completion counters.
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;
  localparam int RD_W_DEF   = 3;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/mem_access_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store sequencer in front of a combinational-read
// data memory. Optional address bounds faulting: define MAU_BOUNDS_CHECK_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic [DATA_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [RD_W-1:0]   rsp_rd,
  output logic              rsp_fault,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_reg, state_next;
  logic              wr_reg;
  logic [DATA_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [RD_W-1:0]   rd_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic [RD_W-1:0]   rsp_rd_reg;
  logic              rsp_fault_reg;
  logic              fault;
  logic              load_inc;
  logic              store_inc;

`ifdef MAU_BOUNDS_CHECK_EN
  assign fault       = (addr_reg >= DATA_W'(DEPTH));
  assign mem_address = addr_reg;
`else
  // Out-of-range addresses alias modulo DEPTH; nothing can fault.
  assign fault       = 1'b0;
  assign mem_address = DATA_W'(addr_reg[AW-1:0]);
`endif

  assign mem_wdata = wdata_reg;

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_write  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        mem_write  = wr_reg && !fault;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rd_reg        <= '0;
      rsp_data_reg  <= '0;
      rsp_rd_reg    <= '0;
      rsp_fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        wr_reg    <= req_write;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        rd_reg    <= req_rd;
      end
      // Response fields are captured once and then held through RESP.
      if (state_reg == ISSUE) begin
        rsp_data_reg  <= (!wr_reg && !fault) ? mem_rdata : '0;
        rsp_rd_reg    <= rd_reg;
        rsp_fault_reg <= fault;
      end
    end
  end

  assign rsp_data  = rsp_data_reg;
  assign rsp_rd    = rsp_rd_reg;
  assign rsp_fault = rsp_fault_reg;

  assign load_inc  = (state_reg == ISSUE) && !wr_reg && !fault;
  assign store_inc = mem_write;

  sat_counter #(.WIDTH(CNT_W)) u_load_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (load_inc),
    .count (load_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_store_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (store_inc),
    .count (store_cnt)
  );

endmodule
